// File: rtl/cla_pipe_adder_pkg.sv
// rtl/cla_pipe_adder_pkg.sv - shared opcodes and lookahead helpers for cla_pipe_adder
//
// Purpose: operation encodings, group-count helper and the flat carry-lookahead
//          sum-of-products function used by both lookahead levels.
// Ports:   none (package)

package cla_pipe_adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Widest propagate/generate vector the lookahead function accepts; bounds both
   // GROUP and the number of groups.
   localparam int LA_MAX = 64;

   function automatic int grp_count(input int width, input int group);
      return width / group;
   endfunction

   // Carry out of the lowest n positions, written as an explicit sum of products:
   //   c_in & p[n-1..0]  |  OR_j ( g[j] & p[n-1..j+1] )
   // With n a constant at every call site this folds to a two-level network, so no
   // carry ripples through the positions. n = 0 returns c_in unchanged.
   function automatic logic la_carry(
      input logic [LA_MAX-1:0] p,
      input logic [LA_MAX-1:0] g,
      input logic              c_in,
      input int                n
   );
      logic carry;
      logic term;
      carry = c_in;
      for (int k = 0; k < n; k++) begin
         carry = carry & p[k];
      end
      for (int j = 0; j < n; j++) begin
         term = g[j];
         for (int k = j + 1; k < n; k++) begin
            term = term & p[k];
         end
         carry = carry | term;
      end
      return carry;
   endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - first-level carry-lookahead group
//
// Purpose: one GROUP-bit CLA slice. Produces the group propagate/generate and, given
//          the carry into the group, the local carries and sum bits.
// Ports:
//   i_p     in   GROUP  bit propagates (a ^ b_eff)
//   i_g     in   GROUP  bit generates  (a & b_eff)
//   i_c_in  in   1      carry into bit 0 of the group
//   o_gp    out  1      group propagate
//   o_gg    out  1      group generate
//   o_c     out  GROUP  carry into each bit of the group
//   o_s     out  GROUP  sum bits

module cla_group
   import cla_pipe_adder_pkg::*;
#(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] i_p,
   input  logic [GROUP-1:0] i_g,
   input  logic             i_c_in,
   output logic             o_gp,
   output logic             o_gg,
   output logic [GROUP-1:0] o_c,
   output logic [GROUP-1:0] o_s
);

   always_comb begin
      o_gp = &i_p;
      // Group generate is the carry out of the group with a zero carry in.
      o_gg = la_carry(LA_MAX'(i_p), LA_MAX'(i_g), 1'b0, GROUP);
      o_c  = '0;
      for (int i = 0; i < GROUP; i++) begin
         o_c[i] = la_carry(LA_MAX'(i_p), LA_MAX'(i_g), i_c_in, i);
      end
      o_s = i_p ^ o_c;
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined two-level carry-lookahead adder/subtractor
//
// Purpose: WIDTH-bit add/subtract built from GROUP-bit CLA slices and a flat
//          group-level lookahead, with valid/ready on both sides and full
//          back-pressure. PIPE=2 registers after group P/G, PIPE=1 only at the output.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      beat accepted this cycle when in_valid is also high
//   a, b       in   WIDTH  operands
//   cin        in   1      carry in (ignored when sub=1)
//   sub        in   1      0: a+b+cin, 1: a-b
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   cout       out  1      carry out of MSB (sub: 1 = no borrow)
//   ovf        out  1      two's-complement overflow
//   zero       out  1      sum == 0

module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int GROUP = 4,
   parameter int PIPE  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = grp_count(WIDTH, GROUP);

   generate
      if ((WIDTH % GROUP) != 0 || (PIPE != 1 && PIPE != 2) ||
          GROUP > LA_MAX || NG > LA_MAX) begin : g_param_check
         $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and PIPE must be 1 or 2");
      end
   endgenerate

   // Whole pipeline moves as one: it advances whenever the output slot is empty or
   // being drained this cycle.
   logic w_adv;
   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv;

   // ---------------- stage 0: operand prep and group P/G ----------------
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH-1:0] w_g;
   logic             w_c0;
   logic [NG-1:0]    w_gp;
   logic [NG-1:0]    w_gg;

   always_comb begin
      w_b_eff = (sub == OP_SUB) ? ~b : b;
      w_c0    = (sub == OP_ADD) ? cin : 1'b1;
      w_p     = a ^ w_b_eff;
      w_g     = a & w_b_eff;
   end

   always_comb begin
      w_gp = '0;
      w_gg = '0;
      for (int k = 0; k < NG; k++) begin
         w_gp[k] = &w_p[k*GROUP +: GROUP];
         w_gg[k] = la_carry(LA_MAX'(w_p[k*GROUP +: GROUP]),
                            LA_MAX'(w_g[k*GROUP +: GROUP]), 1'b0, GROUP);
      end
   end

   // ---------------- optional stage-1 register ----------------
   logic [WIDTH-1:0] w_x_p;
   logic [WIDTH-1:0] w_x_g;
   logic [NG-1:0]    w_x_gp;
   logic [NG-1:0]    w_x_gg;
   logic             w_x_c0;
   logic             w_x_a_msb;
   logic             w_x_b_msb;
   logic             w_x_valid;

   generate
      if (PIPE == 2) begin : g_stage1
         logic [WIDTH-1:0] r_s1_p;
         logic [WIDTH-1:0] r_s1_g;
         logic [NG-1:0]    r_s1_gp;
         logic [NG-1:0]    r_s1_gg;
         logic             r_s1_c0;
         logic             r_s1_a_msb;
         logic             r_s1_b_msb;
         logic             r_s1_valid;

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_s1_valid <= 1'b0;
            end else if (w_adv) begin
               r_s1_valid <= in_valid;
            end
         end

         // Only operand MSBs travel on; the rest of a/b_eff is already folded into p/g.
         always_ff @(posedge clk) begin
            if (w_adv && in_valid) begin
               r_s1_p     <= w_p;
               r_s1_g     <= w_g;
               r_s1_gp    <= w_gp;
               r_s1_gg    <= w_gg;
               r_s1_c0    <= w_c0;
               r_s1_a_msb <= a[WIDTH-1];
               r_s1_b_msb <= w_b_eff[WIDTH-1];
            end
         end

         assign w_x_p     = r_s1_p;
         assign w_x_g     = r_s1_g;
         assign w_x_gp    = r_s1_gp;
         assign w_x_gg    = r_s1_gg;
         assign w_x_c0    = r_s1_c0;
         assign w_x_a_msb = r_s1_a_msb;
         assign w_x_b_msb = r_s1_b_msb;
         assign w_x_valid = r_s1_valid;
      end else begin : g_no_stage1
         assign w_x_p     = w_p;
         assign w_x_g     = w_g;
         assign w_x_gp    = w_gp;
         assign w_x_gg    = w_gg;
         assign w_x_c0    = w_c0;
         assign w_x_a_msb = a[WIDTH-1];
         assign w_x_b_msb = w_b_eff[WIDTH-1];
         assign w_x_valid = in_valid;
      end
   endgenerate

   // ---------------- stage 2: group lookahead, sums, flags ----------------
   // w_gc[k] is the carry into group k; w_gc[NG] is the carry out of the MSB.
   logic [NG:0] w_gc;

   always_comb begin
      w_gc = '0;
      for (int k = 0; k <= NG; k++) begin
         w_gc[k] = la_carry(LA_MAX'(w_x_gp), LA_MAX'(w_x_gg), w_x_c0, k);
      end
   end

   logic [WIDTH-1:0] w_sum;
   logic [NG-1:0]    w_grp_gp_unused;
   logic [NG-1:0]    w_grp_gg_unused;
   logic [WIDTH-1:0] w_grp_c_unused;

   // The slices recompute their own P/G; the lookahead uses the copy registered in
   // stage 1, so those outputs are left dangling here.
   generate
      for (genvar k = 0; k < NG; k++) begin : g_grp
         cla_group #(.GROUP(GROUP)) u_grp (
            .i_p    (w_x_p[k*GROUP +: GROUP]),
            .i_g    (w_x_g[k*GROUP +: GROUP]),
            .i_c_in (w_gc[k]),
            .o_gp   (w_grp_gp_unused[k]),
            .o_gg   (w_grp_gg_unused[k]),
            .o_c    (w_grp_c_unused[k*GROUP +: GROUP]),
            .o_s    (w_sum[k*GROUP +: GROUP])
         );
      end
   endgenerate

   logic w_ovf;
   assign w_ovf = (w_x_a_msb == w_x_b_msb) & (w_sum[WIDTH-1] != w_x_a_msb);

   // ---------------- output register ----------------
   logic             r_out_valid;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b0;
      end else if (w_adv) begin
         r_out_valid <= w_x_valid;
         // Data only moves with a real beat, so a bubble leaves the last result in place.
         if (w_x_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_gc[NG];
            r_ovf  <= w_ovf;
            r_zero <= (w_sum == '0);
         end
      end
   end

   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule
